// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and parameter defaults for the dot-product sequencer.
// No logic: only the state encoding and the width derivations.
// Backpressure: not applicable.
package dot_product_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dps_state_e;

    localparam int DPS_W_A     = 32;
    localparam int DPS_W_B     = 32;
    localparam int DPS_MAX_LEN = 1024;
    localparam int DPS_LEN_W   = $clog2(DPS_MAX_LEN + 1);
    localparam int DPS_ACC_W   = DPS_W_A + DPS_W_B + $clog2(DPS_MAX_LEN);

endpackage

// File: rtl/dot_product_sequencer_accumulator.sv
// Dot-product accumulator register: clear, or add addend when add_vld is high.
// Latency: 1 cycle from add_vld to the updated acc.
// Backpressure: none; clear takes priority over add.
module dps_accumulator #(
    parameter int ACC_W = 74
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clr,
    input  logic             add_vld,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_vld) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/reg_mult.sv
// Registered unsigned multiplier with a full-width product.
// Latency: 1 cycle from en to p.
// Backpressure: none; p holds its value while en is low.
module reg_mult #(
    parameter int W_a = 32,
    parameter int W_b = 32
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               en,
    input  logic [W_a-1:0]     a,
    input  logic [W_b-1:0]     b,
    output logic [W_a+W_b-1:0] p
);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            p <= '0;
        end else if (en) begin
            p <= (W_a+W_b)'(a) * (W_a+W_b)'(b);
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams {a,b} pairs through a registered multiplier and sums the products.
// Latency: last beat at edge T -> out_valid after edge T+2; 1 pair/cycle in RUN.
// Backpressure: in_ready only in RUN; result held in DONE until out_ready.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int W_A     = DPS_W_A,
    parameter int W_B     = DPS_W_B,
    parameter int MAX_LEN = DPS_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ACC_W   = W_A + W_B + $clog2(MAX_LEN)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             clamped,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_A-1:0]   a,
    input  logic [W_B-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    dps_state_e         state_q, state_d;
    logic [LEN_W-1:0]   remaining_q;
    logic [W_A-1:0]     a_q;
    logic [W_B-1:0]     b_q;
    logic               op_vld_q;
    logic               prod_vld_q;
    logic [W_A+W_B-1:0] product;
    logic               beat;
    logic               job_start;

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign beat      = in_valid && in_ready;
    assign job_start = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (beat && remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
            // Leave once the operand stage is empty; the product stage adds this cycle.
            ST_DRAIN: if (!op_vld_q) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            clamped     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_vld_q    <= 1'b0;
            prod_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_vld_q   <= beat;
            prod_vld_q <= op_vld_q;
            if (job_start) begin
                remaining_q <= (len > MAX_LEN_L) ? MAX_LEN_L : len;
                clamped     <= (len > MAX_LEN_L);
            end else if (beat) begin
                remaining_q <= remaining_q - LEN_W'(1);
            end
            if (beat) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    reg_mult #(
        .W_a (W_A),
        .W_b (W_B)
    ) u_mult (
        .Clock  (Clock),
        .Resetn (Resetn),
        .en     (op_vld_q),
        .a      (a_q),
        .b      (b_q),
        .p      (product)
    );

    dps_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .clr     (job_start),
        .add_vld (prod_vld_q),
        .addend  (ACC_W'(product)),
        .acc     (result)
    );

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: table of short jobs plus corner sequences.
module tb_dot_product_sequencer;

    localparam int LEN_W = 11;
    localparam int ACC_W = 74;

    logic             Clock = 1'b0;
    logic             Resetn;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             clamped;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    dot_product_sequencer dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .clamped   (clamped),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        int                len;
        logic [3:0][31:0]  av;
        logic [3:0][31:0]  bv;
        int                bub;
        logic [ACC_W-1:0]  exp;
    } vec_t;

    vec_t vecs[5];

    function automatic void chk(input string nm, input logic [ACC_W-1:0] got,
                                input logic [ACC_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic run_job(input int jl, input logic [3:0][31:0] av,
                           input logic [3:0][31:0] bv, input int bub,
                           input logic [ACC_W-1:0] exp, input string nm);
        int k;
        start = 1'b1;
        len   = LEN_W'(jl);
        step();
        start = 1'b0;
        chk({nm, ".busy"}, ACC_W'(busy), 1);
        chk({nm, ".clamped"}, ACC_W'(clamped), 0);
        for (int i = 0; i < jl; i++) begin
            if (i > 0) begin
                for (int g = 0; g < bub; g++) step();
            end
            in_valid = 1'b1;
            a = av[i];
            b = bv[i];
            k = 0;
            while (!in_ready && k < 20) begin
                step();
                k++;
            end
            if (!in_ready) chk({nm, ".in_ready_timeout"}, 0, 1);
            step();
            in_valid = 1'b0;
        end
        chk({nm, ".drain_in_ready"}, ACC_W'(in_ready), 0);
        chk({nm, ".out_valid_T"}, ACC_W'(out_valid), 0);
        step();
        chk({nm, ".out_valid_T1"}, ACC_W'(out_valid), 0);
        step();
        chk({nm, ".out_valid_T2"}, ACC_W'(out_valid), 1);
        chk({nm, ".result"}, result, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, ".idle_busy"}, ACC_W'(busy), 0);
    endtask

    initial begin
        logic [ACC_W-1:0] held;
        int beats;
        int cyc;

        vecs[0] = '{4, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 0, 74'd70};
        vecs[1] = '{3, {32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                       {32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 2,
                       74'h2_FFFF_FFFA_0000_0003};
        vecs[2] = '{1, {32'd0, 32'd0, 32'd0, 32'd7}, {32'd0, 32'd0, 32'd0, 32'd9}, 0, 74'd63};
        vecs[3] = '{2, {32'd0, 32'd0, 32'd100, 32'd0}, {32'd0, 32'd0, 32'd3, 32'd123}, 1, 74'd300};
        vecs[4] = '{4, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd1, 32'd1, 32'd1, 32'd1}, 3, 74'd100};

        Resetn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst.busy", ACC_W'(busy), 0);
        chk("rst.in_ready", ACC_W'(in_ready), 0);
        chk("rst.out_valid", ACC_W'(out_valid), 0);
        chk("rst.clamped", ACC_W'(clamped), 0);
        chk("rst.result", result, 0);
        Resetn = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].len, vecs[v].av, vecs[v].bv, vecs[v].bub, vecs[v].exp,
                    $sformatf("vec%0d", v));
        end

        // len=0: straight to DONE, no beats taken
        in_valid = 1'b1; a = 32'd5; b = 32'd5;
        start = 1'b1; len = '0;
        step();
        start = 1'b0;
        chk("len0.out_valid", ACC_W'(out_valid), 1);
        chk("len0.in_ready", ACC_W'(in_ready), 0);
        chk("len0.result", result, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("len0.idle", ACC_W'(busy), 0);

        // Stall in DONE with start pulses; start on the handshake cycle is ignored
        start = 1'b1; len = 11'd1;
        step();
        start = 1'b0; in_valid = 1'b1; a = 32'd11; b = 32'd13;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("stall.out_valid0", ACC_W'(out_valid), 1);
        held = result;
        chk("stall.result0", held, 143);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0); len = 11'd3;
            step();
            chk($sformatf("stall.out_valid%0d", i + 1), ACC_W'(out_valid), 1);
            chk($sformatf("stall.result%0d", i + 1), result, 143);
        end
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        chk("stall.hs_busy", ACC_W'(busy), 0);
        step();
        chk("stall.still_idle", ACC_W'(busy), 0);

        // Reset in the middle of a job
        start = 1'b1; len = 11'd4;
        step();
        start = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd9;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        Resetn = 1'b0;
        step();
        chk("midrst.busy", ACC_W'(busy), 0);
        chk("midrst.in_ready", ACC_W'(in_ready), 0);
        chk("midrst.out_valid", ACC_W'(out_valid), 0);
        chk("midrst.result", result, 0);
        Resetn = 1'b1;
        step();
        run_job(2, {32'd0, 32'd0, 32'd5, 32'd3}, {32'd0, 32'd0, 32'd6, 32'd4}, 0, 74'd42,
                "postrst");

        // Clamp: len = MAX_LEN+5, stream held valid
        start = 1'b1; len = 11'd1029;
        step();
        start = 1'b0;
        chk("clamp.flag", ACC_W'(clamped), 1);
        in_valid = 1'b1; a = 32'd1; b = 32'd1;
        beats = 0; cyc = 0;
        while (!out_valid && cyc < 1200) begin
            if (in_valid && in_ready) beats++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("clamp.done", ACC_W'(out_valid), 1);
        chk("clamp.beats", ACC_W'(beats), 1024);
        chk("clamp.result", result, 1024);
        chk("clamp.flag_held", ACC_W'(clamped), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("clamp.idle", ACC_W'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
